gpr: RTL and testbench

GPR -- requirements
Module: gpr

---
 rtl/gpr.sv | 38 +++
 tb/tb_gpr.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gpr.sv
// gpr: 32x32 register file with two combinational read ports, an unbypassed debug port,
// optional write-through forwarding, and register 0 hardwired to zero.
`timescale 1ns/100ps
module gpr #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  debug_addr,
  output logic [31:0] debug_data
);
  logic [31:0] regs_q [32];
  logic        wr_d;
  logic        fwd1, fwd2;
  assign wr_d = write_en && (write_addr != 5'd0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_d) begin
      regs_q[write_addr] <= write_data;
    end
  end
  // Forwarding is gated by reset so a held write cannot leak through while clearing.
  always_comb begin
    fwd1       = BYPASS && !reset && wr_d && (read_addr1 == write_addr);
    fwd2       = BYPASS && !reset && wr_d && (read_addr2 == write_addr);
    read_data1 = fwd1 ? write_data : (read_addr1 == 5'd0) ? 32'h0 : regs_q[read_addr1];
    read_data2 = fwd2 ? write_data : (read_addr2 == 5'd0) ? 32'h0 : regs_q[read_addr2];
    debug_data = (debug_addr == 5'd0) ? 32'h0 : regs_q[debug_addr];
  end
endmodule

// File: tb/tb_gpr.sv
// tb_gpr: scoreboard bench driving a bypassed and an unbypassed gpr from shared stimulus.
`timescale 1ns/100ps
module tb_gpr;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_addr1, read_addr2, write_addr, debug_addr;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
  logic [31:0] m [32];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpr #(.BYPASS(1'b1)) u_b (
    .clk(clk), .reset(reset), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_b), .read_data2(rd2_b), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .debug_addr(debug_addr), .debug_data(dbg_b)
  );
  gpr #(.BYPASS(1'b0)) u_n (
    .clk(clk), .reset(reset), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_n), .read_data2(rd2_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .debug_addr(debug_addr), .debug_data(dbg_n)
  );

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    @(posedge clk);
    if (a != 5'd0) m[a] = d;
    #1 write_en = 1'b0; write_data = 32'hx;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i); read_addr2 = 5'(31 - i); debug_addr = 5'(i);
      #1;
      exp_q.push_back(m[i]); exp_q.push_back(m[31 - i]); exp_q.push_back(m[i]); exp_q.push_back(m[i]);
      e = exp_q.pop_front(); checks++;
      if (rd1_b !== e) begin failures++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", i, rd1_b, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_b !== e) begin failures++; $display("FAIL reset_rd2[%0d] got=%h exp=%h", 31 - i, rd2_b, e); end
      e = exp_q.pop_front(); checks++;
      if (dbg_b !== e) begin failures++; $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, dbg_b, e); end
      e = exp_q.pop_front(); checks++;
      if (dbg_n !== e) begin failures++; $display("FAIL reset_dbg_nb[%0d] got=%h exp=%h", i, dbg_n, e); end
    end
  endtask

  task automatic test_basic;
    wr(5'd8, 32'h00c0ffee); wr(5'd9, 32'hbaadc0de); wr(5'd31, 32'hdeadbeef);
    read_addr1 = 5'd8; read_addr2 = 5'd9; debug_addr = 5'd31;
    #1;
    exp_q.push_back(32'h00c0ffee); exp_q.push_back(32'hbaadc0de);
    exp_q.push_back(32'hdeadbeef); exp_q.push_back(32'hbaadc0de);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL basic_rd1 got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", rd2_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL basic_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_n !== e) begin failures++; $display("FAIL basic_rd2_nb got=%h exp=%h", rd2_n, e); end
  endtask

  task automatic test_zero;
    read_addr1 = 5'd0; debug_addr = 5'd0;
    write_en = 1'b1; write_addr = 5'd0; write_data = 32'hffffffff;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL zero_pre got=%h exp=%h", rd1_b, e); end
    @(posedge clk); #1 write_en = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL zero_post got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL zero_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_n !== e) begin failures++; $display("FAIL zero_post_nb got=%h exp=%h", rd1_n, e); end
  endtask

  task automatic test_bypass;
    wr(5'd5, 32'h1);
    read_addr1 = 5'd5; read_addr2 = 5'd5; debug_addr = 5'd5;
    write_en = 1'b1; write_addr = 5'd5; write_data = 32'h2;
    #1;
    exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h1);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL bypass_pre_rd1 got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin failures++; $display("FAIL bypass_pre_rd2 got=%h exp=%h", rd2_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL bypass_pre_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_n !== e) begin failures++; $display("FAIL nobypass_pre_rd1 got=%h exp=%h", rd1_n, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_n !== e) begin failures++; $display("FAIL nobypass_pre_dbg got=%h exp=%h", dbg_n, e); end
    @(posedge clk); m[5] = 32'h2;
    #1 write_en = 1'b0;
    exp_q.push_back(m[5]); exp_q.push_back(m[5]); exp_q.push_back(m[5]);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL bypass_post_rd1 got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL bypass_post_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_n !== e) begin failures++; $display("FAIL nobypass_post_rd1 got=%h exp=%h", rd1_n, e); end
  endtask

  task automatic test_async_reset;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    read_addr1 = 5'd3; read_addr2 = 5'd31; debug_addr = 5'd7;
    @(negedge clk); #1;
    exp_q.push_back(32'd31); exp_q.push_back(32'd7);
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin failures++; $display("FAIL fill_rd2 got=%h exp=%h", rd2_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL fill_dbg got=%h exp=%h", dbg_b, e); end
    write_en = 1'b1; write_addr = 5'd3; write_data = 32'h55;
    #1 reset = 1'b1;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    #0.5;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL areset_rd1_bypass got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin failures++; $display("FAIL areset_rd2 got=%h exp=%h", rd2_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL areset_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_n !== e) begin failures++; $display("FAIL areset_rd1_nb got=%h exp=%h", rd1_n, e); end
    #0.5 reset = 1'b0; write_en = 1'b0;
    test_reset;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wr(5'd7, 32'hA); wr(5'd7, 32'hB);
    write_en = 1'b0; write_addr = 5'd7; write_data = 32'hC;
    @(posedge clk); #1;
    read_addr1 = 5'd7; debug_addr = 5'd7;
    #1;
    exp_q.push_back(m[7]); exp_q.push_back(m[7]); exp_q.push_back(m[7]);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin failures++; $display("FAIL b2b_rd1 got=%h exp=%h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_b !== e) begin failures++; $display("FAIL b2b_dbg got=%h exp=%h", dbg_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_n !== e) begin failures++; $display("FAIL b2b_rd1_nb got=%h exp=%h", rd1_n, e); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    reset = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
    read_addr1 = '0; read_addr2 = '0; debug_addr = '0;
    #12 reset = 1'b0;
    test_reset;
    @(negedge clk);
    test_basic;
    test_zero;
    test_bypass;
    test_async_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
